branch_comparator: RTL and testbench

//   Branch-condition resolver for the ID stage of the pipelined CPU.

---
 rtl/branch_comparator_if.sv | 42 ++++
 rtl/branch_comparator.sv | 73 +++++++
 tb/tb_branch_comparator.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/branch_comparator_if.sv
// Operand, decode-select and result bundle for the ID-stage branch comparator.
// The BRANCH_EXT_EN macro adds the BLT/BGE/BLTU/BGEU selects and the lt/ltu flags.
interface branch_comparator_if #(
   parameter int WIDTH = 32
);
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             BEQ;
   logic             BNE;
`ifdef BRANCH_EXT_EN
   logic             BLT;
   logic             BGE;
   logic             BLTU;
   logic             BGEU;
   logic             lt;
   logic             ltu;
`endif
   logic             branch;
   logic             branch_q;
   logic             eq;
   logic             illegal;

`ifdef BRANCH_EXT_EN
   modport master (
      output A, B, BEQ, BNE, BLT, BGE, BLTU, BGEU,
      input  branch, branch_q, eq, illegal, lt, ltu
   );
   modport slave (
      input  A, B, BEQ, BNE, BLT, BGE, BLTU, BGEU,
      output branch, branch_q, eq, illegal, lt, ltu
   );
`else
   modport master (
      output A, B, BEQ, BNE,
      input  branch, branch_q, eq, illegal
   );
   modport slave (
      input  A, B, BEQ, BNE,
      output branch, branch_q, eq, illegal
   );
`endif
endinterface

// File: rtl/branch_comparator.sv
// ID-stage branch resolver: combinational branch/eq/illegal plus a registered branch_q.
// Optional macro BRANCH_EXT_EN adds signed/unsigned less-than conditions.
module branch_comparator #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   branch_comparator_if.slave bus
);

`ifdef BRANCH_EXT_EN
   localparam int NSEL = 6;
`else
   localparam int NSEL = 2;
`endif
   localparam logic [NSEL-1:0] SEL_ONE = NSEL'(1);

   logic            eq;
   logic [NSEL-1:0] sel_raw;
   logic [NSEL-1:0] sel;
   logic [NSEL-1:0] hit;
   logic            multi;
   logic            branch;
   logic            branch_d;
   logic            branch_q;

   assign eq = (bus.A == bus.B);

`ifdef BRANCH_EXT_EN
   logic lt;
   logic ltu;
   assign lt      = ($signed(bus.A) < $signed(bus.B));
   assign ltu     = (bus.A < bus.B);
   assign sel_raw = {bus.BGEU, bus.BLTU, bus.BGE, bus.BLT, bus.BNE, bus.BEQ};
   assign hit     = {~ltu, ltu, ~lt, lt, ~eq, eq};
   assign bus.lt  = lt;
   assign bus.ltu = ltu;
`else
   assign sel_raw = {bus.BNE, bus.BEQ};
   assign hit     = {~eq, eq};
`endif

   // An unknown select must never redirect fetch, so only a clean 1 counts.
   generate
      for (genvar gi = 0; gi < NSEL; gi++) begin : g_sel
         assign sel[gi] = (sel_raw[gi] === 1'b1);
      end
   endgenerate

   always_comb begin
      multi    = 1'b0;
      branch   = 1'b0;
      branch_d = 1'b0;
      // Clearing the lowest set bit leaves something only if two or more were set.
      multi    = |(sel & (sel - SEL_ONE));
      branch   = ~multi & (|(sel & hit));
      branch_d = branch;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         branch_q <= 1'b0;
      end else begin
         branch_q <= branch_d;
      end
   end

   assign bus.eq       = eq;
   assign bus.illegal  = multi;
   assign bus.branch   = branch;
   assign bus.branch_q = branch_q;

endmodule

// File: tb/tb_branch_comparator.sv
// Scoreboarded random bench for branch_comparator; a driver queues model results,
// a negedge monitor compares them, and a final sequence exercises asynchronous reset.
module tb_branch_comparator;

   localparam int WIDTH = 32;

   // select bit order: 0 BEQ, 1 BNE, 2 BLT, 3 BGE, 4 BLTU, 5 BGEU
   localparam logic [5:0] S_BEQ  = 6'b000001;
   localparam logic [5:0] S_BNE  = 6'b000010;
   localparam logic [5:0] S_BLT  = 6'b000100;
   localparam logic [5:0] S_BLTU = 6'b010000;

   typedef struct {
      logic br;
      logic eq;
      logic ill;
      logic lt;
      logic ltu;
   } exp_t;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_pass;
   bit   mon_en;
   logic prev_br;
   exp_t exp_q[$];

   branch_comparator_if #(.WIDTH(WIDTH)) bus ();

   branch_comparator #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic act, input logic req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %b expected %b", name, act, req);
   endtask

   // Reference: count the asserted selects, then evaluate the one condition named.
   function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                  input logic [5:0] s);
      exp_t e;
      int   cnt;
      longint sa, sb;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      e.eq  = (a == b);
      e.lt  = (sa < sb);
      e.ltu = ({1'b0, a} < {1'b0, b});
      cnt = 0;
      for (int i = 0; i < 6; i++) cnt += int'(s[i]);
      e.ill = (cnt > 1);
      e.br  = 1'b0;
      if (cnt == 1) begin
         if (s[0]) e.br = e.eq;
         if (s[1]) e.br = !e.eq;
         if (s[2]) e.br = e.lt;
         if (s[3]) e.br = !e.lt;
         if (s[4]) e.br = e.ltu;
         if (s[5]) e.br = !e.ltu;
      end
      return e;
   endfunction

   task automatic drive(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [5:0] s);
      bus.A   = a;
      bus.B   = b;
      bus.BEQ = s[0];
      bus.BNE = s[1];
`ifdef BRANCH_EXT_EN
      bus.BLT  = s[2];
      bus.BGE  = s[3];
      bus.BLTU = s[4];
      bus.BGEU = s[5];
`endif
   endtask

   // One transaction per cycle: drive shortly after the rising edge, queue the model result.
   task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [5:0] s);
      logic [5:0] sv;
      @(posedge clk);
      #2;
`ifdef BRANCH_EXT_EN
      sv = s;
`else
      sv = {4'b0000, s[1:0]};
`endif
      drive(a, b, sv);
      exp_q.push_back(model(a, b, sv));
   endtask

   always @(negedge clk) begin
      if (mon_en && exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         check("branch",  bus.branch,  e.br);
         check("eq",      bus.eq,      e.eq);
         check("illegal", bus.illegal, e.ill);
         check("branch_q", bus.branch_q, prev_br);
`ifdef BRANCH_EXT_EN
         check("lt",  bus.lt,  e.lt);
         check("ltu", bus.ltu, e.ltu);
`endif
         $display("txn A=%h B=%h sel=%b%b -> branch=%b eq=%b illegal=%b branch_q=%b",
                  bus.A, bus.B, bus.BNE, bus.BEQ, bus.branch, bus.eq, bus.illegal,
                  bus.branch_q);
         prev_br = e.br;
      end
   end

   initial begin
      logic [WIDTH-1:0] a, b;
      logic [5:0]       s;
      int               r;
      int               waited;
      n_checks = 0;
      n_pass   = 0;
      mon_en   = 1'b0;
      prev_br  = 1'b0;
      drive('0, '0, 6'b0);
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #1 check("reset_branch_q", bus.branch_q, 1'b0);
      repeat (3) @(posedge clk);
      #1 check("reset_hold_branch_q", bus.branch_q, 1'b0);
      @(posedge clk);
      #2 rst_n = 1'b1;
      mon_en = 1'b1;

      // Directed cases
      issue(32'd5, 32'd5, 6'b0);
      issue(32'd5, 32'd5, S_BEQ);
      issue(32'd5, 32'd5, S_BNE);
      issue(32'd5, 32'd4, S_BNE);
      issue(32'd5, 32'd4, S_BEQ);
      issue(32'd7, 32'd7, S_BEQ | S_BNE);
      issue(32'd7, 32'd9, S_BEQ | S_BNE);
      issue(32'hFFFF_FFFF, 32'h7FFF_FFFF, S_BNE);
`ifdef BRANCH_EXT_EN
      issue(32'hFFFF_FFFF, 32'd1, S_BLT);
      issue(32'hFFFF_FFFF, 32'd1, S_BLTU);
      issue(32'd3, 32'd3, S_BLT | S_BLTU);
`endif

      // Random: mostly one-hot or idle selects, some collisions, frequent equal operands
      for (int i = 0; i < 300; i++) begin
         a = $urandom;
         b = ($urandom_range(0, 3) == 0) ? a : $urandom;
         r = $urandom_range(0, 9);
         if (r < 2)      s = 6'b0;
         else if (r < 8) s = 6'b1 << $urandom_range(0, 5);
         else            s = 6'($urandom);
         issue(a, b, s);
      end
      issue('0, '0, 6'b0);

      waited = 0;
      while (exp_q.size() > 0 && waited < 20) begin
         @(posedge clk);
         waited++;
      end
      check("scoreboard_drained", exp_q.size() == 0, 1'b1);
      mon_en = 1'b0;

      // Asynchronous reset in the middle of a cycle with branch held high
      @(posedge clk);
      #2 drive(32'd5, 32'd5, S_BEQ);
      @(posedge clk);
      #1 check("pre_reset_branch_q", bus.branch_q, 1'b1);
      #3 rst_n = 1'b0;
      #1 check("async_reset_branch_q", bus.branch_q, 1'b0);
      check("branch_during_reset", bus.branch, 1'b1);
      check("eq_during_reset", bus.eq, 1'b1);
      @(posedge clk);
      #1 check("reset_edge_branch_q", bus.branch_q, 1'b0);
      #2 rst_n = 1'b1;
      #1 check("post_release_branch_q", bus.branch_q, 1'b0);
      @(posedge clk);
      #1 check("first_edge_branch_q", bus.branch_q, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
